uart_frame_rx_fsm: RTL and testbench



---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_frame_rx_fsm.sv | 188 ++++++++++++++++++
 tb/tb_uart_frame_rx_fsm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and helpers
// used by both the TX and RX frame FSMs.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam string PARITY_NONE = "NONE";
    localparam string PARITY_EVEN = "EVEN";
    localparam string PARITY_ODD  = "ODD";

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    function automatic int baud_cnt(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Data is zero-extended by the caller; extra zeros do not change the parity.
    function automatic logic parity_bit(input logic [15:0] data, input parity_mode_e mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial input plus a registered copy used to
// detect falling edges. All flops reset to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= uart_rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_sync = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_frame_rx_fsm.sv
// UART frame receiver: start, FRAME_WD data bits LSB first, optional parity, one stop.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around the bit centre.
module uart_frame_rx_fsm
    import uart_pkg::*;
#(
    parameter int    CLK_FREQUENCE = 50_000_000,
    parameter int    BAUD_RATE     = 9600,
    parameter string PARITY        = "NONE",
    parameter int    FRAME_WD      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                uart_rx,
    output logic [FRAME_WD-1:0] data_frame,
    output logic                rx_done,
    output logic                frame_err,
    output logic                parity_err
);

    localparam int BAUD_CNT = uart_pkg::baud_cnt(CLK_FREQUENCE, BAUD_RATE);
    localparam int MID      = BAUD_CNT / 2;
    localparam int BCW      = $clog2(BAUD_CNT);
    localparam int NCW      = $clog2(FRAME_WD + 1);

    localparam parity_mode_e PAR_MODE = (PARITY == PARITY_EVEN) ? PAR_EVEN :
                                        (PARITY == PARITY_ODD)  ? PAR_ODD  : PAR_NONE;
    localparam bit PAR_EN = (PAR_MODE != PAR_NONE);

`ifdef UART_RX_MAJORITY_EN
    localparam int DECIDE = MID + 1;
`else
    localparam int DECIDE = MID;
`endif

    localparam logic [BCW-1:0] CNT_LAST = BCW'(BAUD_CNT - 1);
    localparam logic [BCW-1:0] CNT_DEC  = BCW'(DECIDE);
    localparam logic [NCW-1:0] BIT_LAST = NCW'(FRAME_WD - 1);

    logic                rx_sync;
    logic                rx_fall;
    rx_state_e           state;
    rx_state_e           state_next;
    logic [BCW-1:0]      baud_cnt;
    logic [NCW-1:0]      bit_cnt;
    logic [FRAME_WD-1:0] shift;
    logic                par_flag;
    logic                bit_val;
    logic                at_decide;
    logic                at_wrap;
    logic                sample_data;
    logic                sample_par;
    logic                capture;
    logic                bit_adv;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    assign at_decide = (baud_cnt == CNT_DEC);
    assign at_wrap   = (baud_cnt == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
    logic samp_a;
    logic samp_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (baud_cnt == BCW'(MID - 1))
                samp_a <= rx_sync;
            if (baud_cnt == BCW'(MID))
                samp_b <= rx_sync;
        end
    end

    assign bit_val = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // STOP leaves at the decision point so a back-to-back start edge is not missed.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (rx_fall)
                    state_next = ST_START;
            end
            ST_START: begin
                if (at_decide && bit_val)
                    state_next = ST_IDLE;
                else if (at_wrap)
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                if (at_wrap && (bit_cnt == BIT_LAST))
                    state_next = PAR_EN ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (at_wrap)
                    state_next = ST_STOP;
            end
            ST_STOP: begin
                if (at_decide)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sample_data = 1'b0;
        sample_par  = 1'b0;
        capture     = 1'b0;
        bit_adv     = 1'b0;
        case (state)
            ST_DATA: begin
                sample_data = at_decide;
                bit_adv     = at_wrap && (bit_cnt != BIT_LAST);
            end
            ST_PARITY: sample_par = at_decide;
            ST_STOP:   capture    = at_decide;
            default: ;
        endcase
    end

    // The baud counter restarts on every state entry and idles at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if ((state_next != state) || (state == ST_IDLE) || at_wrap)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state != ST_DATA)
                bit_cnt <= '0;
            else if (bit_adv)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= '0;
            par_flag   <= 1'b0;
            data_frame <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_done    <= capture;
            frame_err  <= capture & ~bit_val;
            parity_err <= capture & par_flag;

            if (capture)
                data_frame <= shift;

            if (sample_data) begin
                for (int i = 0; i < FRAME_WD; i++) begin
                    if (bit_cnt == NCW'(i))
                        shift[i] <= bit_val;
                end
            end

            if (state == ST_IDLE)
                par_flag <= 1'b0;
            else if (sample_par)
                par_flag <= bit_val ^ parity_bit(16'(shift), PAR_MODE);
        end
    end

endmodule

// File: tb/tb_uart_frame_rx_fsm.sv
// Directed bench for uart_frame_rx_fsm: a no-parity and an even-parity receiver
// at 10 clocks per bit, 6-bit frames, each fed by its own serial line.
module tb_uart_frame_rx_fsm;
    import uart_pkg::*;

    localparam int BAUD = 10;
    localparam int W    = 6;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         line_n = 1'b1;
    logic         line_p = 1'b1;
    logic [W-1:0] data_frame_n;
    logic         rx_done_n;
    logic         frame_err_n;
    logic         parity_err_n;
    logic [W-1:0] data_frame_p;
    logic         rx_done_p;
    logic         frame_err_p;
    logic         parity_err_p;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int stray  = 0;

    int           n_n = 0;
    logic [W-1:0] dat_n [16];
    logic         fe_n  [16];
    logic         pe_n  [16];
    int           at_n  [16];
    int           n_p = 0;
    logic [W-1:0] dat_p [16];
    logic         fe_p  [16];
    logic         pe_p  [16];

    uart_frame_rx_fsm #(
        .CLK_FREQUENCE (50_000_000),
        .BAUD_RATE     (5_000_000),
        .PARITY        ("NONE"),
        .FRAME_WD      (W)
    ) dut_n (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (line_n),
        .data_frame (data_frame_n),
        .rx_done    (rx_done_n),
        .frame_err  (frame_err_n),
        .parity_err (parity_err_n)
    );

    uart_frame_rx_fsm #(
        .CLK_FREQUENCE (50_000_000),
        .BAUD_RATE     (5_000_000),
        .PARITY        ("EVEN"),
        .FRAME_WD      (W)
    ) dut_p (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (line_p),
        .data_frame (data_frame_p),
        .rx_done    (rx_done_p),
        .frame_err  (frame_err_p),
        .parity_err (parity_err_p)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe; error flags seen without a strobe are counted as stray.
    always @(negedge clk) begin
        if (rx_done_n) begin
            if (n_n < 16) begin
                dat_n[n_n] = data_frame_n;
                fe_n[n_n]  = frame_err_n;
                pe_n[n_n]  = parity_err_n;
                at_n[n_n]  = cyc;
            end
            n_n++;
        end
        if (rx_done_p) begin
            if (n_p < 16) begin
                dat_p[n_p] = data_frame_p;
                fe_p[n_p]  = frame_err_p;
                pe_p[n_p]  = parity_err_p;
            end
            n_p++;
        end
        if ((!rx_done_n && (frame_err_n || parity_err_n)) ||
            (!rx_done_p && (frame_err_p || parity_err_p)))
            stray++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives nbits line levels LSB first, each held for one bit period.
    task automatic applyStimulus(input int sel, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel == 0)
                line_n = bits[i];
            else
                line_p = bits[i];
            repeat (BAUD) @(negedge clk);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_n"}, 32'({rx_done_n, frame_err_n, parity_err_n, data_frame_n}), 32'd0);
        checkOutput({tag, "_p"}, 32'({rx_done_p, frame_err_p, parity_err_p, data_frame_p}), 32'd0);
        checkOutput({tag, "_state"}, 32'(dut_n.state), 32'(ST_IDLE));
    endtask

    int base;
    int t0;

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        base = n_n;
        t0   = cyc;
        applyStimulus(0, 16'({1'b1, 6'h2B, 1'b0}), 8);
        repeat (20) @(negedge clk);
        checkOutput("single_count", 32'(n_n - base), 32'd1);
        checkOutput("single_data", 32'(dat_n[base]), 32'h2B);
        checkOutput("single_flags", 32'({fe_n[base], pe_n[base]}), 32'd0);
        checkOutput("single_latency", 32'(at_n[base] - t0), 32'd79);
        checkOutput("single_hold", 32'(data_frame_n), 32'h2B);

        base = n_n;
        applyStimulus(0, 16'({1'b1, 6'h2B, 1'b0}), 8);
        applyStimulus(0, 16'({1'b1, 6'h35, 1'b0}), 8);
        repeat (20) @(negedge clk);
        checkOutput("b2b_count", 32'(n_n - base), 32'd2);
        checkOutput("b2b_data0", 32'(dat_n[base]), 32'h2B);
        checkOutput("b2b_data1", 32'(dat_n[base + 1]), 32'h35);
        checkOutput("b2b_spacing", 32'(at_n[base + 1] - at_n[base]), 32'd80);
        checkOutput("b2b_flags", 32'({fe_n[base], pe_n[base], fe_n[base + 1], pe_n[base + 1]}), 32'd0);

        base = n_p;
        applyStimulus(1, 16'({1'b1, 1'b1, 6'h2B, 1'b0}), 9);
        repeat (20) @(negedge clk);
        checkOutput("par_bad_count", 32'(n_p - base), 32'd1);
        checkOutput("par_bad_data", 32'(dat_p[base]), 32'h2B);
        checkOutput("par_bad_perr", 32'(pe_p[base]), 32'd1);
        checkOutput("par_bad_ferr", 32'(fe_p[base]), 32'd0);

        base = n_p;
        applyStimulus(1, 16'({1'b1, 1'b0, 6'h2B, 1'b0}), 9);
        repeat (20) @(negedge clk);
        checkOutput("par_ok_count", 32'(n_p - base), 32'd1);
        checkOutput("par_ok_perr", 32'(pe_p[base]), 32'd0);

        base = n_n;
        t0   = cyc;
        line_n = 1'b0;
        repeat (3) @(negedge clk);
        line_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("glitch_in_start", 32'(dut_n.state), 32'(ST_START));
        @(negedge clk);
        checkOutput("glitch_back_idle", 32'(dut_n.state), 32'(ST_IDLE));
        repeat (20) @(negedge clk);
        checkOutput("glitch_no_strobe", 32'(n_n - base), 32'd0);

        base = n_n;
        applyStimulus(0, 16'({1'b0, 6'h2A, 1'b0}), 8);
        line_n = 1'b0;
        repeat (40) @(negedge clk);
        line_n = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus(0, 16'({1'b1, 6'h15, 1'b0}), 8);
        repeat (20) @(negedge clk);
        checkOutput("ferr_count", 32'(n_n - base), 32'd2);
        checkOutput("ferr_first", 32'({fe_n[base], pe_n[base]}), 32'b10);
        checkOutput("ferr_first_data", 32'(dat_n[base]), 32'h2A);
        checkOutput("ferr_second_data", 32'(dat_n[base + 1]), 32'h15);
        checkOutput("ferr_second_flag", 32'(fe_n[base + 1]), 32'd0);

        base = n_n;
        line_n = 1'b0;
        repeat (BAUD) @(negedge clk);
        line_n = 1'b1;
        repeat (3 * BAUD + BAUD / 2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkReset("midrst1");
        @(negedge clk);
        checkReset("midrst2");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("abort_no_strobe", 32'(n_n - base), 32'd0);
        applyStimulus(0, 16'({1'b1, 6'h3F, 1'b0}), 8);
        repeat (20) @(negedge clk);
        checkOutput("after_rst_count", 32'(n_n - base), 32'd1);
        checkOutput("after_rst_data", 32'(dat_n[base]), 32'h3F);
        checkOutput("after_rst_flags", 32'({fe_n[base], pe_n[base]}), 32'd0);

        checkOutput("stray_flags", 32'(stray), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
